// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO with a valid/ready read port.
// Framing errors and overruns are kept as sticky flags until cleared.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_ADDR_W  = 3
) (
   input  logic                   i_Clock,
   input  logic                   i_Reset,
   input  logic                   i_RX_Serial,
   output logic [7:0]             o_RX_Byte,
   output logic                   o_RX_Valid,
   input  logic                   i_RX_Ready,
   output logic [FIFO_ADDR_W:0]   o_Count,
   output logic                   o_Frame_Err,
   output logic                   o_Overrun,
   input  logic                   i_Clear_Err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int DEPTH = 1 << FIFO_ADDR_W;
   localparam logic [CNT_W-1:0]     HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_ADDR_W:0] FULL_CNT = (FIFO_ADDR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic                   r_Sync1;
   logic                   r_Sync2;
   logic                   w_RX;

   state_t                 r_State;
   state_t                 w_State_Next;
   logic [CNT_W-1:0]       r_Clk_Cnt;
   logic [CNT_W-1:0]       w_Cnt_Next;
   logic [2:0]             r_Bit_Idx;
   logic [2:0]             w_Idx_Next;
   logic [7:0]             r_Shift;
   logic [7:0]             w_Shift_Next;
   logic                   w_Good_Stop;
   logic                   w_Bad_Stop;
   logic                   r_Push_Pend;

   logic [7:0]             r_Mem [DEPTH];
   logic [FIFO_ADDR_W-1:0] r_Wr_Ptr;
   logic [FIFO_ADDR_W-1:0] r_Rd_Ptr;
   logic [FIFO_ADDR_W-1:0] w_Rd_Next;
   logic [FIFO_ADDR_W:0]   r_Count;
   logic [FIFO_ADDR_W:0]   w_Count_Next;
   logic [7:0]             r_Head;
   logic [7:0]             w_Head_Next;
   logic                   r_Valid;
   logic                   w_Pop;
   logic                   w_Full;
   logic                   w_Push;
   logic                   w_Drop;
   logic                   r_Frame_Err;
   logic                   r_Overrun;

   // Idle-high reset values keep a reset from looking like a start bit.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_Sync1 <= 1'b1;
         r_Sync2 <= 1'b1;
      end else begin
         r_Sync1 <= i_RX_Serial;
         r_Sync2 <= r_Sync1;
      end
   end

   assign w_RX = r_Sync2;

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_State     <= S_IDLE;
         r_Clk_Cnt   <= '0;
         r_Bit_Idx   <= '0;
         r_Shift     <= '0;
         r_Push_Pend <= 1'b0;
      end else begin
         r_State     <= w_State_Next;
         r_Clk_Cnt   <= w_Cnt_Next;
         r_Bit_Idx   <= w_Idx_Next;
         r_Shift     <= w_Shift_Next;
         r_Push_Pend <= w_Good_Stop;
      end
   end

   always_comb begin
      w_State_Next = r_State;
      w_Cnt_Next   = r_Clk_Cnt + 1'b1;
      w_Idx_Next   = r_Bit_Idx;
      w_Shift_Next = r_Shift;
      w_Good_Stop  = 1'b0;
      w_Bad_Stop   = 1'b0;
      case (r_State)
         S_IDLE: begin
            w_Cnt_Next = '0;
            if (!w_RX) begin
               w_State_Next = S_START;
            end
         end
         S_START: begin
            if (r_Clk_Cnt == HALF_CNT) begin
               w_Cnt_Next = '0;
               w_Idx_Next = '0;
               w_State_Next = w_RX ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_Clk_Cnt == LAST_CNT) begin
               w_Cnt_Next = '0;
               w_Shift_Next[r_Bit_Idx] = w_RX;
               if (r_Bit_Idx == 3'd7) begin
                  w_State_Next = S_STOP;
               end else begin
                  w_Idx_Next = r_Bit_Idx + 1'b1;
               end
            end
         end
         S_STOP: begin
            if (r_Clk_Cnt == LAST_CNT) begin
               w_Cnt_Next = '0;
               if (w_RX) begin
                  w_Good_Stop  = 1'b1;
                  w_State_Next = S_IDLE;
               end else begin
                  w_Bad_Stop   = 1'b1;
                  w_State_Next = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            w_Cnt_Next = '0;
            if (w_RX) begin
               w_State_Next = S_IDLE;
            end
         end
         default: begin
            w_Cnt_Next   = '0;
            w_State_Next = S_IDLE;
         end
      endcase
   end

   // A push into a full FIFO is still taken when the head is popped in the same cycle.
   assign w_Pop  = r_Valid && i_RX_Ready;
   assign w_Full = (r_Count == FULL_CNT);
   assign w_Push = r_Push_Pend && (!w_Full || w_Pop);
   assign w_Drop = r_Push_Pend && w_Full && !w_Pop;
   assign w_Rd_Next = w_Pop ? r_Rd_Ptr + 1'b1 : r_Rd_Ptr;

   always_comb begin
      w_Count_Next = r_Count;
      if (w_Push && !w_Pop) begin
         w_Count_Next = r_Count + 1'b1;
      end else if (w_Pop && !w_Push) begin
         w_Count_Next = r_Count - 1'b1;
      end
   end

   // The head register bypasses memory when the new head is the byte being written now.
   always_comb begin
      w_Head_Next = r_Head;
      if (w_Count_Next != '0) begin
         if (w_Push && (w_Rd_Next == r_Wr_Ptr)) begin
            w_Head_Next = r_Shift;
         end else begin
            w_Head_Next = r_Mem[w_Rd_Next];
         end
      end
   end

   always_ff @(posedge i_Clock) begin
      if (w_Push) begin
         r_Mem[r_Wr_Ptr] <= r_Shift;
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_Wr_Ptr <= '0;
         r_Rd_Ptr <= '0;
         r_Count  <= '0;
         r_Head   <= '0;
         r_Valid  <= 1'b0;
      end else begin
         if (w_Push) begin
            r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
         end
         r_Rd_Ptr <= w_Rd_Next;
         r_Count  <= w_Count_Next;
         r_Head   <= w_Head_Next;
         r_Valid  <= (w_Count_Next != '0);
      end
   end

   // A set event in the same cycle as a clear wins.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_Frame_Err <= 1'b0;
         r_Overrun   <= 1'b0;
      end else begin
         if (w_Bad_Stop) begin
            r_Frame_Err <= 1'b1;
         end else if (i_Clear_Err) begin
            r_Frame_Err <= 1'b0;
         end
         if (w_Drop) begin
            r_Overrun <= 1'b1;
         end else if (i_Clear_Err) begin
            r_Overrun <= 1'b0;
         end
      end
   end

   assign o_RX_Byte   = r_Head;
   assign o_RX_Valid  = r_Valid;
   assign o_Count     = r_Count;
   assign o_Frame_Err = r_Frame_Err;
   assign o_Overrun   = r_Overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames in, expected bytes queued,
// a negedge monitor checks every accepted byte against the queue.
module tb_uart_rx_fifo;

   localparam int CPB     = 217;
   localparam int ADDR_W  = 3;
   localparam int LAT_NOM = 2 + (CPB - 1) / 2 + 9 * CPB + 1;

   logic              clock;
   logic              reset;
   logic              rxLine;
   logic              rxReady;
   logic              clearErr;
   logic [7:0]        rxByte;
   logic              rxValid;
   logic [ADDR_W:0]   count;
   logic              frameErr;
   logic              overrun;

   int                checks = 0;
   int                errors = 0;
   int                lat    = 0;
   logic [7:0]        expQ[$];
   logic [7:0]        monExp;
   event              frameStart;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .FIFO_ADDR_W  (ADDR_W)
   ) dut (
      .i_Clock     (clock),
      .i_Reset     (reset),
      .i_RX_Serial (rxLine),
      .o_RX_Byte   (rxByte),
      .o_RX_Valid  (rxValid),
      .i_RX_Ready  (rxReady),
      .o_Count     (count),
      .o_Frame_Err (frameErr),
      .o_Overrun   (overrun),
      .i_Clear_Err (clearErr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every byte the consumer accepts must be the oldest outstanding expectation.
   always @(negedge clock) begin
      if (!reset && rxValid && rxReady) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL pop_unexpected: got 0x%02h expected no byte", rxByte);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("pop_byte", rxByte, monExp);
         end
      end
   end

   task automatic driveLevel(input logic v, input int n);
      @(posedge clock);
      #1;
      rxLine = v;
      repeat (n - 1) @(posedge clock);
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic stopLevel);
      @(posedge clock);
      #1;
      rxLine = 1'b0;
      -> frameStart;
      repeat (CPB - 1) @(posedge clock);
      for (int i = 0; i < 8; i++) begin
         driveLevel(data[i], CPB);
      end
      driveLevel(stopLevel, CPB);
   endtask

   task automatic pulseReady();
      @(posedge clock);
      #1;
      rxReady = 1'b1;
      @(posedge clock);
      #1;
      rxReady = 1'b0;
   endtask

   task automatic pulseClear();
      @(posedge clock);
      #1;
      clearErr = 1'b1;
      @(posedge clock);
      #1;
      clearErr = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(posedge clock);
      #1;
      rxReady = 1'b1;
      while (rxValid && n < 64) begin
         @(posedge clock);
         #1;
         n++;
      end
      rxReady = 1'b0;
      checkOutput("drain_bounded", int'(n < 64), 1);
   endtask

   initial begin
      reset    = 1'b1;
      rxLine   = 1'b1;
      rxReady  = 1'b0;
      clearErr = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_byte", rxByte, 8'h00);
      checkOutput("reset_valid", rxValid, 0);
      checkOutput("reset_count", count, 0);
      checkOutput("reset_frame_err", frameErr, 0);
      checkOutput("reset_overrun", overrun, 0);
      reset = 1'b0;
      repeat (5) @(posedge clock);

      // Single byte, latency measured from the start-bit edge.
      expQ.push_back(8'h3F);
      fork
         applyStimulus(8'h3F, 1'b1);
         begin
            @(frameStart);
            lat = 0;
            while (!rxValid && lat < 3000) begin
               @(posedge clock);
               #1;
               lat++;
            end
         end
      join
      // Window: synchronizer phase either way, plus the IDLE clock that registers the start.
      checkOutput("latency_window", int'(lat >= LAT_NOM - 1 && lat <= LAT_NOM + 2), 1);
      checkOutput("single_valid", rxValid, 1);
      checkOutput("single_byte", rxByte, 8'h3F);
      checkOutput("single_count", count, 1);
      pulseReady();
      #1;
      checkOutput("single_count_after_pop", count, 0);
      checkOutput("single_valid_after_pop", rxValid, 0);

      // Framing error followed by a 20-bit break, then a good byte.
      applyStimulus(8'h55, 1'b0);
      driveLevel(1'b0, 20 * CPB);
      driveLevel(1'b1, 2 * CPB);
      checkOutput("frame_err_set", frameErr, 1);
      checkOutput("frame_no_push", count, 0);
      checkOutput("frame_overrun_clear", overrun, 0);
      expQ.push_back(8'hC3);
      applyStimulus(8'hC3, 1'b1);
      driveLevel(1'b1, CPB);
      checkOutput("after_break_count", count, 1);
      checkOutput("after_break_byte", rxByte, 8'hC3);
      pulseReady();
      pulseClear();
      #1;
      checkOutput("frame_err_cleared", frameErr, 0);

      // Short low glitch on an idle line.
      driveLevel(1'b0, CPB / 4);
      driveLevel(1'b1, 3 * CPB);
      checkOutput("glitch_count", count, 0);
      checkOutput("glitch_valid", rxValid, 0);
      checkOutput("glitch_frame_err", frameErr, 0);
      checkOutput("glitch_overrun", overrun, 0);

      // Reset in the middle of a frame with a byte already buffered.
      expQ.push_back(8'h5A);
      applyStimulus(8'h5A, 1'b1);
      driveLevel(1'b1, CPB);
      checkOutput("prereset_count", count, 1);
      driveLevel(1'b0, CPB);
      driveLevel(1'b0, CPB);
      driveLevel(1'b1, CPB / 2);
      @(posedge clock);
      #3;
      reset = 1'b1;
      expQ.delete();
      #1;
      checkOutput("midreset_byte", rxByte, 8'h00);
      checkOutput("midreset_valid", rxValid, 0);
      checkOutput("midreset_count", count, 0);
      checkOutput("midreset_frame_err", frameErr, 0);
      checkOutput("midreset_overrun", overrun, 0);
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b0;
      driveLevel(1'b1, CPB);
      expQ.push_back(8'h34);
      applyStimulus(8'h34, 1'b1);
      driveLevel(1'b1, CPB);
      checkOutput("postreset_count", count, 1);
      checkOutput("postreset_byte", rxByte, 8'h34);
      pulseReady();

      // Back-to-back fill to full, drain in order.
      for (int i = 0; i < 8; i++) begin
         expQ.push_back(8'(i));
         applyStimulus(8'(i), 1'b1);
      end
      driveLevel(1'b1, CPB);
      checkOutput("fill_count", count, 8);
      checkOutput("fill_head", rxByte, 8'h00);
      checkOutput("fill_overrun", overrun, 0);
      drain();
      checkOutput("drain_count", count, 0);

      // Refill, then a ninth byte that must be dropped.
      for (int i = 0; i < 8; i++) begin
         expQ.push_back(8'(i));
         applyStimulus(8'(i), 1'b1);
      end
      applyStimulus(8'hAA, 1'b1);
      driveLevel(1'b1, CPB);
      checkOutput("overrun_set", overrun, 1);
      checkOutput("overrun_count", count, 8);
      pulseClear();
      #1;
      checkOutput("overrun_cleared", overrun, 0);

      // Push at full with a pop landing on the same clock edge.
      expQ.push_back(8'h99);
      fork
         applyStimulus(8'h99, 1'b1);
         begin
            @(frameStart);
            repeat (lat - 1) @(posedge clock);
            #1;
            rxReady = 1'b1;
            @(posedge clock);
            #1;
            rxReady = 1'b0;
         end
      join
      driveLevel(1'b1, CPB);
      checkOutput("simul_count", count, 8);
      checkOutput("simul_overrun", overrun, 0);
      checkOutput("simul_head", rxByte, 8'h01);
      drain();
      checkOutput("simul_drain_count", count, 0);
      checkOutput("queue_empty", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
